// File: rtl/ctrl_pkg.sv
// Encodings shared by the multicycle controller: opcodes, datapath select values,
// FSM states and the packed control word driven to the datapath each cycle.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_R_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP,
    S_JAL
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dest;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       jal_dest;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control word out.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDest;
  logic       RegWrite;
  logic [1:0] MemToReg;
  logic       Jal_Dest;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDest,
           RegWrite, MemToReg, Jal_Dest, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDest,
           RegWrite, MemToReg, Jal_Dest, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           instr_done, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control word decode; zero latency. Only FETCH and
// MEM_WRITE look at mem_ready, so memory stalls hold every other select stable.
module mc_ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IDLE: ;
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // ALUOut <= PC+4 + (imm<<2): branch target ready before BRANCH
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dest   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.reg_dest   = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4, so $31 gets the return address on this edge
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.jal_dest   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller: state register, latched opcode, next-state logic.
// CPI 3-5 plus one cycle per mem_ready=0 in FETCH/MEM_READ/MEM_WRITE.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  state_t     state;
  logic [5:0] op_q;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_q <= bus.opcode;
          case (bus.opcode)
            OP_RTYPE:     state <= S_EXEC_R;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_FETCH;
          endcase
        end
        S_EXEC_R:    state <= S_R_WB;
        S_R_WB:      state <= S_FETCH;
        // IR may already be changing; steer lw/sw from the copy taken in DECODE
        S_MEM_ADDR:  state <= (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (bus.mem_ready) state <= S_MEM_WB;
        S_MEM_WB:    state <= S_FETCH;
        S_MEM_WRITE: if (bus.mem_ready) state <= S_FETCH;
        S_BRANCH:    state <= S_FETCH;
        S_JUMP:      state <= S_FETCH;
        S_JAL:       state <= S_FETCH;
        default:     state <= S_IDLE;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegDest     = ctrl.reg_dest;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.Jal_Dest    = ctrl.jal_dest;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.illegal_op  = (state == S_DECODE) && !is_supported(bus.opcode);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase sequences built from the
// instruction timing rules, compared cycle by cycle against the full control word.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, regdst, regw;
    logic [1:0] m2r;
    logic       jal, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       done, ill;
  } cw_t;

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_EXEC_R, P_R_WB, P_MEM_ADDR,
                P_MEM_READ, P_MEM_WB, P_MEM_WRITE, P_BRANCH, P_JUMP, P_JAL} phase_t;

  typedef struct {
    phase_t ph;
    logic   rdy;
    logic   bad;
  } ent_t;

  typedef struct {
    logic [5:0] op;
    int         cyc;
    int         done;
    int         ill;
  } vec_t;

  vec_t tbl[8];
  logic [5:0] legal_ops[6];

  function automatic cw_t sample();
    cw_t c;
    c.pcw = bus.PCWrite;   c.pcwc = bus.PCWriteCond; c.iord = bus.IorD;
    c.mrd = bus.MemRead;   c.mwr = bus.MemWrite;     c.irw = bus.IRWrite;
    c.regdst = bus.RegDest; c.regw = bus.RegWrite;   c.m2r = bus.MemToReg;
    c.jal = bus.Jal_Dest;  c.srca = bus.ALUSrcA;     c.srcb = bus.ALUSrcB;
    c.aluop = bus.ALUOp;   c.pcsrc = bus.PCSource;   c.done = bus.instr_done;
    c.ill = bus.illegal_op;
    return c;
  endfunction

  // Required control word for each phase of an instruction
  function automatic cw_t exp_cw(input phase_t ph, input logic rdy, input logic bad);
    cw_t c;
    c = '0;
    case (ph)
      P_FETCH:     begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      P_DECODE:    begin c.srcb = 2'b11; c.ill = bad; end
      P_EXEC_R:    begin c.srca = 1; c.aluop = 2'b10; end
      P_R_WB:      begin c.regdst = 1; c.regw = 1; c.done = 1; end
      P_MEM_ADDR:  begin c.srca = 1; c.srcb = 2'b10; end
      P_MEM_READ:  begin c.mrd = 1; c.iord = 1; end
      P_MEM_WB:    begin c.regw = 1; c.m2r = 2'b01; c.done = 1; end
      P_MEM_WRITE: begin c.mwr = 1; c.iord = 1; c.done = rdy; end
      P_BRANCH:    begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; c.done = 1; end
      P_JUMP:      begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
      P_JAL:       begin c.pcw = 1; c.pcsrc = 2'b10; c.regw = 1; c.m2r = 2'b10; c.jal = 1; c.done = 1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  task automatic check_cw(input string name, input cw_t got, input cw_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h required=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d required=%0d", name, $time, got, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, let outputs settle, sample
  task automatic drive_sample(input logic [5:0] op, input logic rdy, output cw_t got);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    #1;
    got = sample();
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  // Starts and ends with the controller in FETCH. Opcode is garbage except in DECODE.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    ent_t       q[$];
    cw_t        g;
    logic       bad;
    logic [5:0] opd;
    bad = !(op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03});
    for (int i = 0; i < wf; i++) q.push_back('{P_FETCH, 1'b0, 1'b0});
    q.push_back('{P_FETCH, 1'b1, 1'b0});
    q.push_back('{P_DECODE, 1'($urandom_range(0, 1)), bad});
    case (op)
      6'h00: begin
        q.push_back('{P_EXEC_R, 1'($urandom_range(0, 1)), 1'b0});
        q.push_back('{P_R_WB, 1'($urandom_range(0, 1)), 1'b0});
      end
      6'h23: begin
        q.push_back('{P_MEM_ADDR, 1'($urandom_range(0, 1)), 1'b0});
        for (int i = 0; i < wm; i++) q.push_back('{P_MEM_READ, 1'b0, 1'b0});
        q.push_back('{P_MEM_READ, 1'b1, 1'b0});
        q.push_back('{P_MEM_WB, 1'($urandom_range(0, 1)), 1'b0});
      end
      6'h2b: begin
        q.push_back('{P_MEM_ADDR, 1'($urandom_range(0, 1)), 1'b0});
        for (int i = 0; i < wm; i++) q.push_back('{P_MEM_WRITE, 1'b0, 1'b0});
        q.push_back('{P_MEM_WRITE, 1'b1, 1'b0});
      end
      6'h04: q.push_back('{P_BRANCH, 1'($urandom_range(0, 1)), 1'b0});
      6'h02: q.push_back('{P_JUMP, 1'($urandom_range(0, 1)), 1'b0});
      6'h03: q.push_back('{P_JAL, 1'($urandom_range(0, 1)), 1'b0});
      default: ;
    endcase
    foreach (q[i]) begin
      opd = (q[i].ph == P_DECODE) ? op : 6'($urandom);
      drive_sample(opd, q[i].rdy, g);
      check_cw($sformatf("instr op=%h step=%0d", op, i), g, exp_cw(q[i].ph, q[i].rdy, q[i].bad));
      advance();
    end
  endtask

  initial begin
    cw_t  g;
    int   n, d, il, k;
    bit   ended;
    logic [5:0] op;

    tbl[0] = '{6'h00, 4, 1, 0};
    tbl[1] = '{6'h23, 5, 1, 0};
    tbl[2] = '{6'h2b, 4, 1, 0};
    tbl[3] = '{6'h04, 3, 1, 0};
    tbl[4] = '{6'h02, 3, 1, 0};
    tbl[5] = '{6'h03, 3, 1, 0};
    tbl[6] = '{6'h3f, 2, 0, 1};
    tbl[7] = '{6'h01, 2, 0, 1};
    legal_ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};

    rst = 1'b1;
    bus.opcode = '0;
    bus.mem_ready = 1'b1;

    // Three reset edges, then the IDLE cycle, then the first FETCH
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_sample(6'h00, 1'b1, g);
      check_cw("rst_hold", g, '0);
    end
    rst = 1'b0;
    drive_sample(6'h00, 1'b1, g);
    check_cw("idle_after_rst", g, '0);
    advance();
    drive_sample(6'h00, 1'b1, g);
    check_cw("first_fetch", g, exp_cw(P_FETCH, 1'b1, 1'b0));

    // Cycles per instruction with memory always ready
    for (int i = 0; i < 8; i++) begin
      n = 0; d = 0; il = 0; ended = 0;
      for (k = 0; k < 20; k++) begin
        drive_sample(tbl[i].op, 1'b1, g);
        if (k > 0 && g.mrd && !g.iord) begin
          ended = 1;
          break;
        end
        d += int'(g.done);
        il += int'(g.ill);
        n++;
        advance();
      end
      check_int($sformatf("tbl_cycles op=%h", tbl[i].op), ended ? n : -1, tbl[i].cyc);
      check_int($sformatf("tbl_done op=%h", tbl[i].op), d, tbl[i].done);
      check_int($sformatf("tbl_illegal op=%h", tbl[i].op), il, tbl[i].ill);
    end

    run_instr(6'h2b, 0, 3);
    run_instr(6'h03, 0, 0);
    run_instr(6'h3f, 0, 0);
    run_instr(6'h23, 1, 2);
    run_instr(6'h00, 2, 0);

    // Reset while sw waits in MEM_WRITE: write must drop, no done pulse
    drive_sample(6'h2b, 1'b1, g);
    check_cw("midrst_fetch", g, exp_cw(P_FETCH, 1'b1, 1'b0));
    advance();
    drive_sample(6'h2b, 1'b0, g);
    check_cw("midrst_decode", g, exp_cw(P_DECODE, 1'b0, 1'b0));
    advance();
    drive_sample(6'h00, 1'b0, g);
    check_cw("midrst_addr", g, exp_cw(P_MEM_ADDR, 1'b0, 1'b0));
    advance();
    drive_sample(6'h00, 1'b0, g);
    check_cw("midrst_write_wait", g, exp_cw(P_MEM_WRITE, 1'b0, 1'b0));
    rst = 1'b1;
    advance();
    rst = 1'b0;
    drive_sample(6'h00, 1'b0, g);
    check_cw("midrst_idle", g, '0);
    advance();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) < 6) begin
        op = legal_ops[$urandom_range(0, 5)];
      end else begin
        op = 6'($urandom);
        if (op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03}) op = 6'h3f;
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
